// File: rtl/uart_tx_serializer_pkg.sv
// rtl/uart_tx_serializer_pkg.sv - shared types and constants for the UART transmit serialiser
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic bit params_legal(input int data_bits, input int parity, input int stop_bits);
        return (data_bits >= 5) && (data_bits <= 9) &&
               (parity >= PARITY_NONE) && (parity <= PARITY_ODD) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte handshake between upstream logic and the UART serialiser
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - frames one byte per handshake onto tx, paced by baud_tick
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_tx_serializer_if.slave   up,
    output logic                  baud_en,
    input  logic                  baud_tick,
    output logic                  tx,
    output logic                  busy
);

    if (!params_legal(DATA_BITS, PARITY, STOP_BITS)) begin : g_param_check
        $error("uart_tx_serializer: illegal DATA_BITS/PARITY/STOP_BITS");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    tx_state_t            state;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic [3:0]           bit_cnt;
    logic                 ready_q;

    assign up.tx_ready = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            par_bit <= 1'b0;
            bit_cnt <= '0;
            tx      <= 1'b1;
            ready_q <= 1'b1;
            busy    <= 1'b0;
            baud_en <= 1'b0;
        end else begin
            case (state)
                // baud_tick is deliberately not looked at here: the generator is disabled
                ST_IDLE: begin
                    if (up.tx_valid) begin
                        shreg   <= up.tx_data;
                        par_bit <= (PARITY == PARITY_ODD) ? ~^up.tx_data : ^up.tx_data;
                        state   <= ST_START;
                        tx      <= 1'b0;
                        baud_en <= 1'b1;
                        ready_q <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        state   <= ST_DATA;
                        tx      <= shreg[0];
                        bit_cnt <= '0;
                    end
                end
                ST_DATA: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            if (PARITY != PARITY_NONE) begin
                                state <= ST_PAR;
                                tx    <= par_bit;
                            end else begin
                                state   <= ST_STOP;
                                tx      <= 1'b1;
                                bit_cnt <= '0;
                            end
                        end else begin
                            shreg   <= shreg >> 1;
                            tx      <= shreg[1];
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                ST_PAR: begin
                    if (baud_tick) begin
                        state   <= ST_STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= ST_IDLE;
                            baud_en <= 1'b0;
                            ready_q <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    tx      <= 1'b1;
                    baud_en <= 1'b0;
                    ready_q <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
